// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequences the multi-cycle divider and HI/LO writes for DIV/DIVU/MFHI/MFLO/MTHI/MTLO
module div_seq_ctrl #(
  parameter int DIV_LAT = 32,
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           op_valid,
  output logic           op_ready,
  input  logic [5:0]     funct,
  input  logic [W-1:0]   rs_data,
  input  logic [W-1:0]   rt_data,
  input  logic           flush,
  output logic           div_rst,
  output logic [5:0]     div_signal,
  output logic [W-1:0]   div_a,
  output logic [W-1:0]   div_b,
  input  logic [2*W-1:0] div_dataout,
  input  logic [W-1:0]   hi_in,
  input  logic [W-1:0]   lo_in,
  output logic           hi_we,
  output logic           lo_we,
  output logic [W-1:0]   hi_wdata,
  output logic [W-1:0]   lo_wdata,
  output logic           mf_valid,
  output logic [W-1:0]   mf_data,
  output logic           busy
);
  localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010, F_MTLO = 6'b010011;
  localparam int CW = $clog2(DIV_LAT + 1);
  localparam logic [CW-1:0] LAST = CW'(DIV_LAT - 1);
  typedef enum logic [2:0] {IDLE, CLR, RUN, OUT, WB} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [5:0] fn;
  logic acc, is_div;
  assign op_ready = (state == IDLE) & ~rst;
  assign busy = state != IDLE;
  assign acc = op_valid & op_ready;
  assign is_div = funct[5:1] == 5'b01101;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      fn <= '0;
      div_rst <= 1'b1;
      div_signal <= '0;
      div_a <= '0;
      div_b <= '0;
      hi_we <= 1'b0;
      lo_we <= 1'b0;
      hi_wdata <= '0;
      lo_wdata <= '0;
      mf_valid <= 1'b0;
      mf_data <= '0;
    end else begin
      div_rst <= 1'b0;
      hi_we <= 1'b0;
      lo_we <= 1'b0;
      mf_valid <= 1'b0;
      case (state)
        IDLE: if (acc) begin
          if (is_div && rt_data != '0) begin
            div_a <= rs_data;
            div_b <= rt_data;
            fn <= funct;
            div_rst <= 1'b1;
            state <= CLR;
          end else if (is_div) begin
            // divide by zero bypasses the divider entirely
            hi_wdata <= rs_data;
            lo_wdata <= '1;
            hi_we <= 1'b1;
            lo_we <= 1'b1;
            state <= WB;
          end else if (funct == F_MFHI || funct == F_MFLO) begin
            mf_valid <= 1'b1;
            mf_data <= funct == F_MFHI ? hi_in : lo_in;
          end else if (funct == F_MTHI) begin
            hi_we <= 1'b1;
            hi_wdata <= rs_data;
          end else if (funct == F_MTLO) begin
            lo_we <= 1'b1;
            lo_wdata <= rs_data;
          end
        end
        CLR, RUN, OUT: if (flush) begin
          div_rst <= 1'b1;
          div_signal <= '0;
          state <= IDLE;
        end else if (state == CLR) begin
          cnt <= '0;
          div_signal <= fn;
          state <= RUN;
        end else if (state == RUN) begin
          cnt <= cnt + 1'b1;
          div_signal <= cnt == LAST ? 6'b111111 : fn;
          state <= cnt == LAST ? OUT : RUN;
        end else begin
          hi_wdata <= div_dataout[2*W-1:W];
          lo_wdata <= div_dataout[W-1:0];
          hi_we <= 1'b1;
          lo_we <= 1'b1;
          div_signal <= '0;
          state <= WB;
        end
        WB: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed bench with a behavioural divider, HI/LO register model and write scoreboard
module tb_div_seq_ctrl;
  localparam int W = 32;
  localparam int DIV_LAT = 32;
  localparam logic [5:0] F_DIV = 6'b011010, F_DIVU = 6'b011011;
  localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001;
  logic clk = 1'b0, rst = 1'b0, op_valid = 1'b0, flush = 1'b0;
  logic [5:0] funct = '0;
  logic [W-1:0] rs_data = '0, rt_data = '0;
  logic op_ready, div_rst, hi_we, lo_we, mf_valid, busy;
  logic [5:0] div_signal;
  logic [W-1:0] div_a, div_b, hi_in, lo_in, hi_wdata, lo_wdata, mf_data;
  logic [2*W-1:0] div_dataout;
  logic [W-1:0] hi_reg = '0, lo_reg = '0;
  logic sgn = 1'b0;
  int checks = 0, errors = 0;
  typedef struct {int kind; logic [W-1:0] hi; logic [W-1:0] lo;} exp_t;
  exp_t q[$];
  exp_t e;
  int k;
  int rdy, wb, nrun, nout, nrst;

  always #5 clk = ~clk;

  div_seq_ctrl #(.DIV_LAT(DIV_LAT), .W(W)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .funct(funct),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush), .div_rst(div_rst),
    .div_signal(div_signal), .div_a(div_a), .div_b(div_b), .div_dataout(div_dataout),
    .hi_in(hi_in), .lo_in(lo_in), .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata),
    .lo_wdata(lo_wdata), .mf_valid(mf_valid), .mf_data(mf_data), .busy(busy)
  );

  // environment: HI/LO register file and a divider that learns signedness from its command
  assign hi_in = hi_reg;
  assign lo_in = lo_reg;
  always @(posedge clk) begin
    if (hi_we) hi_reg <= hi_wdata;
    if (lo_we) lo_reg <= lo_wdata;
    if (div_signal == F_DIV) sgn <= 1'b1;
    else if (div_signal == F_DIVU) sgn <= 1'b0;
  end
  assign div_dataout = (div_b == '0) ? '0 :
    sgn ? {W'($signed(div_a) % $signed(div_b)), W'($signed(div_a) / $signed(div_b))}
        : {div_a % div_b, div_a / div_b};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every HI/LO write or mf pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (!rst && (hi_we || lo_we || mf_valid)) begin
      k = mf_valid ? 3 : (hi_we && lo_we) ? 0 : hi_we ? 1 : 2;
      chk("strobe_exclusive", 64'((hi_we | lo_we) & mf_valid), 64'd0);
      chk("sb_pending", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_kind", 64'(k), 64'(e.kind));
        if (k == 3) chk("mf_data", 64'(mf_data), 64'(e.hi));
        if (hi_we) chk("hi_wdata", 64'(hi_wdata), 64'(e.hi));
        if (lo_we) chk("lo_wdata", 64'(lo_wdata), 64'(e.lo));
      end
    end
  end

  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    op_valid = 1'b1;
    funct = f;
    rs_data = a;
    rt_data = b;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic run_div(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el);
    q.push_back('{kind: 0, hi: eh, lo: el});
    issue(f, a, b);
    rdy = 0; wb = 0; nrun = 0; nout = 0; nrst = 0;
    for (int c = 1; c <= 60; c++) begin
      if (op_ready) begin
        rdy = c;
        break;
      end
      if (hi_we && lo_we) wb = c;
      if (div_signal == f) nrun++;
      if (div_signal == 6'b111111) nout++;
      if (div_rst) nrst++;
      @(negedge clk);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_div_rst", 64'(div_rst), 64'd1);
    chk("rst_op_ready", 64'(op_ready), 64'd0);
    chk("rst_outs", 64'({busy, hi_we, lo_we, mf_valid, div_signal}), 64'd0);
    chk("rst_data", 64'(div_a | div_b | hi_wdata | lo_wdata | mf_data), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_div_rst", 64'(div_rst), 64'd0);
    // DIVU 10/3
    run_div(F_DIVU, 32'd10, 32'd3, 32'd1, 32'd3);
    chk("t1_ready_cycle", 64'(rdy), 64'(DIV_LAT + 4));
    chk("t1_wb_cycle", 64'(wb), 64'(DIV_LAT + 3));
    chk("t1_run_cycles", 64'(nrun), 64'(DIV_LAT));
    chk("t1_clr_cycles", 64'(nrst), 64'd1);
    // DIV -7/2
    run_div(F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    chk("t2_wb_cycle", 64'(wb), 64'(DIV_LAT + 3));
    chk("t2_run_cycles", 64'(nrun), 64'(DIV_LAT));
    chk("t2_out_cycles", 64'(nout), 64'd1);
    // DIVU by zero
    run_div(F_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    chk("t3_wb_cycle", 64'(wb), 64'd1);
    chk("t3_ready_cycle", 64'(rdy), 64'd2);
    chk("t3_no_div_cmd", 64'(nrun + nout + nrst), 64'd0);
    // MTHI then MFHI
    q.push_back('{kind: 1, hi: 32'hA5A5_A5A5, lo: 32'h0});
    issue(F_MTHI, 32'hA5A5_A5A5, 32'h0);
    q.push_back('{kind: 3, hi: 32'hA5A5_A5A5, lo: 32'h0});
    issue(F_MFHI, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk("t4_hi_reg", 64'(hi_in), 64'hA5A5_A5A5);
    chk("t4_lo_reg", 64'(lo_in), 64'hFFFF_FFFF);
    // flush mid-RUN
    issue(F_DIVU, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    chk("t5_in_run", 64'(div_signal), 64'(F_DIVU));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_div_rst", 64'(div_rst), 64'd1);
    chk("t5_op_ready", 64'(op_ready), 64'd1);
    repeat (45) @(negedge clk);
    chk("t5_hi_kept", 64'(hi_in), 64'hA5A5_A5A5);
    chk("t5_lo_kept", 64'(lo_in), 64'hFFFF_FFFF);
    // reset mid-RUN
    issue(F_DIVU, 32'd9, 32'd2);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_div_rst", 64'(div_rst), 64'd1);
    chk("t6_div_signal", 64'(div_signal), 64'd0);
    chk("t6_op_ready", 64'(op_ready), 64'd0);
    chk("t6_div_a", 64'(div_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("t6_hi_kept", 64'(hi_in), 64'hA5A5_A5A5);
    run_div(F_DIVU, 32'd10, 32'd3, 32'd1, 32'd3);
    chk("t6_wb_cycle", 64'(wb), 64'(DIV_LAT + 3));
    repeat (3) @(negedge clk);
    chk("t6_hi_reg", 64'(hi_in), 64'd1);
    chk("t6_lo_reg", 64'(lo_in), 64'd3);
    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
